output_backprop_seq: RTL and testbench
======================================

OUTPUT_BACKPROP_SEQ -- requirements
Module: output_backprop_seq

Interface
REQ-001 The block SHALL have parameter N_HIDDEN, default 4, meaning the number of hidden-to-output weights updated per pass (N_HIDDEN >= 1).
REQ-002 The block SHALL have parameter X_W, default 4, meaning target width (unsigned).
REQ-003 The block SHALL have parameter F_W, default 23, meaning final output width (unsigned).
REQ-004 The block SHALL have parameter H_W, default 10, meaning hidden activation width (unsigned).
REQ-005 The block SHALL have parameter W_W, default 8, meaning weight width (two's complement).
REQ-006 The block SHALL have parameter LR_SHIFT, default 4, meaning learning-rate right shift (arithmetic).
REQ-007 clk_i  in  1  single clock; all logic on its rising edge.
REQ-008 rst_i  in  1  reset; synchronous, active-high.
REQ-009 en_i  in  1  backward-pass enable; low stalls the block.
REQ-010 start_i  in  1  one-cycle request to begin a pass.
REQ-011 zero_weight_reset_i  in  1  synchronous abort/clear.
REQ-012 x_i  in  X_W  target value.
REQ-013 final_i  in  F_W  forward-pass output value.
REQ-014 hidden_vals_i  in  N_HIDDEN*H_W  packed hidden activations; entry k at bits [k*H_W +: H_W].
REQ-015 weights_i  in  N_HIDDEN*W_W  packed current weights; entry k at bits [k*W_W +: W_W].
REQ-016 w_o  out  W_W  updated weight for index w_idx_o.
REQ-017 w_idx_o  out  clog2(N_HIDDEN), min 1  index of w_o.
REQ-018 w_valid_o  out  1  w_o/w_idx_o valid this cycle.
REQ-019 busy_o  out  1  high in any state other than IDLE.
REQ-020 b_end_o  out  1  one-cycle pulse marking pass completion.

Function
REQ-021 FSM states SHALL be IDLE, ERR, UPDATE, DONE.
REQ-022 IDLE: on start_i=1 and en_i=1, capture x_i, final_i, hidden_vals_i and weights_i into internal registers, then go to ERR; otherwise stay in IDLE.
REQ-023 ERR: register err = zero-extended x - zero-extended final, computed signed at F_W+1 bits; clear index to 0; go to UPDATE.
REQ-024 UPDATE: each cycle, for index k, compute and output w_o, set w_idx_o=k and w_valid_o=1, then increment k; after k=N_HIDDEN-1, go to DONE.
REQ-025 DONE: b_end_o=1 for exactly one cycle, then go to IDLE.
REQ-026 Arithmetic: grad = 2*err*h_k, signed at F_W+H_W+3 bits with h_k treated as unsigned; delta = grad >>> LR_SHIFT.
REQ-027 Weight update: w_new = sign-extended w_k - delta, saturated to [-2^(W_W-1), 2^(W_W-1)-1]; w_o = w_new.
REQ-028 Latency with en_i held high: start_i at cycle 0 gives w_valid_o for k=0..N_HIDDEN-1 at cycles 2..N_HIDDEN+1, b_end_o at cycle N_HIDDEN+2, and start accepted again from cycle N_HIDDEN+3.
REQ-029 en_i=0 SHALL freeze state, index and captured data, hold w_o/w_idx_o, and force w_valid_o=0 and b_end_o=0; operation resumes where it left off when en_i returns to 1.
REQ-030 start_i while busy_o=1 SHALL be ignored; captured operands are not modified mid-pass.
REQ-031 w_valid_o and b_end_o SHALL never be high in the same cycle.
REQ-032 w_o and w_idx_o SHALL hold their last values while w_valid_o=0.

Reset
REQ-033 rst_i=1 at a clock edge SHALL set state to IDLE and force w_o=0, w_idx_o=0, w_valid_o=0, busy_o=0, b_end_o=0, and clear err, index and captured data; this applies in any state, including mid-pass.
REQ-034 zero_weight_reset_i=1 SHALL have the same effect as rst_i, ranking below rst_i and above en_i and start_i; an aborted pass SHALL NOT produce b_end_o.
REQ-035 Start of a new pass SHALL be possible on the first cycle after either reset is released.

Verification
REQ-036 Defaults, x=5, final=3, h0=8, w0=10, start with en high -> cycle 2: w_valid_o=1, w_idx_o=0, w_o=8; b_end_o at cycle 6.
REQ-037 x=15, final=0, h1=1023, w1=0 -> w_idx_o=1 gives w_o=-128 (0x80), negative saturation.
REQ-038 x=0, final=16, h2=4, w2=120 -> w_o=127 (0x7F), positive saturation; with h3=0, w3=-7, w3 is unchanged at -7.
REQ-039 en_i low for 3 cycles after the k=1 output -> no w_valid_o during the stall; k=2 follows on resume; b_end_o is delayed by 3 cycles.
REQ-040 zero_weight_reset_i asserted during UPDATE at k=2 -> next cycle all outputs 0 and busy_o=0, no b_end_o; a repeated start_i during the pass is ignored.
REQ-041 rst_i asserted in DONE -> b_end_o does not pulse and all outputs are 0; start on the next cycle runs a full pass.

Source files
------------

// File: rtl/output_backprop_seq.sv
// output_backprop_seq
//   Sequential output-layer weight update for a small neural network.
//   A pass captures the target x, the forward output final, the hidden
//   activations and the current hidden-to-output weights. It then emits one
//   updated weight per cycle:
//     w_k' = sat(w_k - ((2 * (x - final) * h_k) >>> LR_SHIFT))
//   The pass ends with a single-cycle b_end_o pulse.
//
// Ports
//   clk_i               rising-edge clock
//   rst_i               synchronous active-high reset
//   en_i                enable; low freezes the pass and masks the strobes
//   start_i             begin a pass (honoured only in IDLE)
//   zero_weight_reset_i synchronous abort/clear, same effect as rst_i
//   x_i, final_i        target and forward-pass output (unsigned)
//   hidden_vals_i       packed hidden activations, entry k at [k*H_W +: H_W]
//   weights_i           packed weights, entry k at [k*W_W +: W_W]
//   w_o, w_idx_o        updated weight and its index (held between strobes)
//   w_valid_o           w_o/w_idx_o strobe
//   busy_o              pass in progress (state != IDLE)
//   b_end_o             pass-complete pulse
module output_backprop_seq #(
    parameter int N_HIDDEN = 4,
    parameter int X_W      = 4,
    parameter int F_W      = 23,
    parameter int H_W      = 10,
    parameter int W_W      = 8,
    parameter int LR_SHIFT = 4
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic                                              en_i,
    input  logic                                              start_i,
    input  logic                                              zero_weight_reset_i,
    input  logic [X_W-1:0]                                    x_i,
    input  logic [F_W-1:0]                                    final_i,
    input  logic [N_HIDDEN*H_W-1:0]                           hidden_vals_i,
    input  logic [N_HIDDEN*W_W-1:0]                           weights_i,
    output logic [W_W-1:0]                                    w_o,
    output logic [((N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1)-1:0] w_idx_o,
    output logic                                              w_valid_o,
    output logic                                              busy_o,
    output logic                                              b_end_o
);

    localparam int IW = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
    // Gradient width: (F_W+1)-bit signed err times (H_W+1)-bit signed h,
    // plus one bit for the factor of 2. This width cannot overflow.
    localparam int GW = F_W + H_W + 3;

    typedef enum logic [1:0] {IDLE, ERR, UPDATE, DONE} state_t;

    state_t                  state_q;
    logic [IW-1:0]           idx_q;
    logic [X_W-1:0]          x_q;
    logic [F_W-1:0]          fin_q;
    logic [N_HIDDEN*H_W-1:0] hid_q;
    logic [N_HIDDEN*W_W-1:0] wgt_q;
    logic [F_W:0]            err_q;

    logic [F_W:0]   err_c;
    logic [H_W-1:0] h_k;
    logic [W_W-1:0] w_k;
    logic [GW-1:0]  err_ext;
    logic [GW-1:0]  h_ext;
    logic [GW-1:0]  grad;
    logic [GW-1:0]  delta;
    logic [GW:0]    diff;
    logic           fits;
    logic [W_W-1:0] w_sat;

    // Both operands are zero-extended to F_W+1 bits. The modular difference
    // is then the exact two's-complement error. This assumes X_W <= F_W.
    assign err_c = {{(F_W + 1 - X_W){1'b0}}, x_q} - {1'b0, fin_q};

    assign h_k = hid_q[idx_q*H_W +: H_W];
    assign w_k = wgt_q[idx_q*W_W +: W_W];

    // Modular GW-bit products are exact here because the true value fits.
    assign err_ext = {{(GW - F_W - 1){err_q[F_W]}}, err_q};
    assign h_ext   = {{(GW - H_W){1'b0}}, h_k};
    assign grad    = (err_ext * h_ext) << 1;
    assign delta   = $signed(grad) >>> LR_SHIFT;

    // One extra bit so the subtraction itself never wraps.
    assign diff = {{(GW + 1 - W_W){w_k[W_W-1]}}, w_k} - {delta[GW-1], delta};

    // The value fits in W_W bits when every bit above the target sign bit
    // matches that sign bit. Otherwise clamp toward the sign of diff.
    assign fits  = (&diff[GW:W_W-1]) | ~(|diff[GW:W_W-1]);
    assign w_sat = fits ? diff[W_W-1:0] : {diff[GW], {(W_W - 1){~diff[GW]}}};

    assign busy_o = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i || zero_weight_reset_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            x_q       <= '0;
            fin_q     <= '0;
            hid_q     <= '0;
            wgt_q     <= '0;
            err_q     <= '0;
            w_o       <= '0;
            w_idx_o   <= '0;
            w_valid_o <= 1'b0;
            b_end_o   <= 1'b0;
        end else if (en_i) begin
            w_valid_o <= 1'b0;
            b_end_o   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        x_q     <= x_i;
                        fin_q   <= final_i;
                        hid_q   <= hidden_vals_i;
                        wgt_q   <= weights_i;
                        state_q <= ERR;
                    end
                end
                ERR: begin
                    err_q   <= err_c;
                    idx_q   <= '0;
                    state_q <= UPDATE;
                end
                UPDATE: begin
                    w_o       <= w_sat;
                    w_idx_o   <= idx_q;
                    w_valid_o <= 1'b1;
                    if (idx_q == IW'(N_HIDDEN - 1)) state_q <= DONE;
                    else                            idx_q   <= idx_q + 1'b1;
                end
                DONE: begin
                    b_end_o <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end else begin
            // Stall: hold everything and mask the strobes.
            w_valid_o <= 1'b0;
            b_end_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_output_backprop_seq.sv
module tb_output_backprop_seq;

    localparam int N  = 4;
    localparam int XW = 4;
    localparam int FW = 23;
    localparam int HW = 10;
    localparam int WW = 8;
    localparam int LR = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            en_i = 1'b0;
    logic            start_i = 1'b0;
    logic            zero_weight_reset_i = 1'b0;
    logic [XW-1:0]   x_i = '0;
    logic [FW-1:0]   final_i = '0;
    logic [N*HW-1:0] hidden_vals_i = '0;
    logic [N*WW-1:0] weights_i = '0;
    logic [WW-1:0]   w_o;
    logic [IW-1:0]   w_idx_o;
    logic            w_valid_o;
    logic            busy_o;
    logic            b_end_o;

    output_backprop_seq #(
        .N_HIDDEN(N), .X_W(XW), .F_W(FW), .H_W(HW), .W_W(WW), .LR_SHIFT(LR)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .start_i(start_i),
        .zero_weight_reset_i(zero_weight_reset_i), .x_i(x_i), .final_i(final_i),
        .hidden_vals_i(hidden_vals_i), .weights_i(weights_i), .w_o(w_o),
        .w_idx_o(w_idx_o), .w_valid_o(w_valid_o), .busy_o(busy_o), .b_end_o(b_end_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_end;
        int idx;
        int w;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   obs_w[N];
    logic rst_last;
    logic [WW-1:0] prev_w;
    logic [IW-1:0] prev_idx;

    int xv, fv;
    int hv[N];
    int wv[N];

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model of one weight update, written with plain integer math.
    function automatic int calc_w(input int x, input int f, input int h, input int w);
        longint err, grad, delta, wn;
        longint wmax, wmin;
        wmax  = (longint'(1) <<< (WW - 1)) - 1;
        wmin  = -(longint'(1) <<< (WW - 1));
        err   = longint'(x) - longint'(f);
        grad  = 2 * err * longint'(h);
        delta = grad >>> LR;
        wn    = longint'(w) - delta;
        if (wn > wmax) wn = wmax;
        if (wn < wmin) wn = wmin;
        return int'(wn);
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_last <= rst_i | zero_weight_reset_i;
    end

    // Monitor: pops the scoreboard whenever the DUT presents a strobe.
    always @(negedge clk) begin
        exp_t e;
        if (w_valid_o && b_end_o) chk("valid_and_end_together", 1, 0);
        if (w_valid_o || b_end_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("kind_is_end[idx %0d]", e.idx), longint'(b_end_o), longint'(e.is_end));
                chk($sformatf("out_cycle[idx %0d end %0d]", e.idx, e.is_end), cyc, e.cyc);
                if (w_valid_o && !e.is_end) begin
                    chk("w_idx_o", longint'(w_idx_o), e.idx);
                    chk($sformatf("w_o[idx %0d]", e.idx), int'($signed(w_o)), e.w);
                    obs_w[w_idx_o] = int'($signed(w_o));
                end
            end
        end
        if (!w_valid_o && rst_last === 1'b0) begin
            chk("w_o_hold", longint'(w_o), longint'(prev_w));
            chk("w_idx_o_hold", longint'(w_idx_o), longint'(prev_idx));
        end
        prev_w   = w_o;
        prev_idx = w_idx_o;
    end

    task automatic check_zero(input string tag);
        chk({tag, "_w_o"}, longint'(w_o), 0);
        chk({tag, "_w_idx_o"}, longint'(w_idx_o), 0);
        chk({tag, "_w_valid_o"}, longint'(w_valid_o), 0);
        chk({tag, "_busy_o"}, longint'(busy_o), 0);
        chk({tag, "_b_end_o"}, longint'(b_end_o), 0);
    endtask

    task automatic drive_ops();
        x_i     = XW'(xv);
        final_i = FW'(fv);
        for (int k = 0; k < N; k++) begin
            hidden_vals_i[k*HW +: HW] = HW'(hv[k]);
            weights_i[k*WW +: WW]     = WW'(wv[k]);
        end
    endtask

    // Runs one pass. The caller must be at a negedge.
    //   sa    : stall after output sa (-1 = no stall), for slen cycles
    //   junk  : random start_i/operand noise during the pass
    //   abort : 0 none, 1 zero_weight_reset_i at k=2, 2 rst_i while in DONE
    task automatic run_pass(input int sa, input int slen, input bit junk, input int abort);
        int s, shift, last, nxt;
        exp_t e;
        s     = cyc + 1;
        shift = (sa >= 0) ? slen : 0;
        drive_ops();
        start_i = 1'b1;
        en_i    = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (abort != 1 || k < 2) begin
                e.is_end = 1'b0;
                e.idx    = k;
                e.w      = calc_w(xv, fv, hv[k], wv[k]);
                e.cyc    = s + 2 + k + ((sa >= 0 && k > sa) ? slen : 0);
                sb.push_back(e);
            end
        end
        if (abort == 0) begin
            e.is_end = 1'b1;
            e.idx    = -1;
            e.w      = 0;
            e.cyc    = s + N + 2 + shift;
            sb.push_back(e);
        end
        last = (abort == 1) ? s + 4 : (abort == 2) ? s + N + 2 : s + N + 2 + shift;
        forever begin
            @(negedge clk);
            if (cyc >= last) break;
            nxt     = cyc + 1;
            start_i = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            if (junk) begin
                x_i     = XW'($urandom);
                final_i = FW'($urandom);
                for (int k = 0; k < N; k++) begin
                    hidden_vals_i[k*HW +: HW] = HW'($urandom);
                    weights_i[k*WW +: WW]     = WW'($urandom);
                end
            end
            en_i = !(sa >= 0 && nxt >= s + 3 + sa && nxt <= s + 2 + sa + slen);
            zero_weight_reset_i = (abort == 1 && nxt == last);
            rst_i               = (abort == 2 && nxt == last);
        end
        start_i             = 1'b0;
        en_i                = 1'b1;
        zero_weight_reset_i = 1'b0;
        rst_i               = 1'b0;
        if (abort != 0) check_zero(abort == 1 ? "abort_zwr" : "abort_rst");
    endtask

    task automatic rand_ops();
        xv = int'($urandom_range(0, 15));
        fv = $urandom_range(0, 1) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 32'h7FFFFF));
        for (int k = 0; k < N; k++) begin
            hv[k] = $urandom_range(0, 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1023));
            wv[k] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout act=%0d exp=%0d", cyc, 0);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_i = 1'b0;

        // Nominal pass; the first start comes right after reset release.
        rand_ops();
        xv = 5; fv = 3; hv[0] = 8; wv[0] = 10;
        run_pass(-1, 0, 1'b0, 0);
        chk("nominal_w0", obs_w[0], 8);

        // Negative saturation; this start lands on the first cycle back in IDLE.
        rand_ops();
        xv = 15; fv = 0; hv[1] = 1023; wv[1] = 0;
        run_pass(-1, 0, 1'b0, 0);
        chk("neg_sat_w1", obs_w[1], -128);

        // Positive saturation, and a zero activation leaves the weight untouched.
        rand_ops();
        xv = 0; fv = 16; hv[2] = 4; wv[2] = 120; hv[3] = 0; wv[3] = -7;
        run_pass(-1, 0, 1'b0, 0);
        chk("pos_sat_w2", obs_w[2], 127);
        chk("zero_h_w3", obs_w[3], -7);

        // Three-cycle stall after the k=1 output.
        rand_ops();
        run_pass(1, 3, 1'b0, 0);

        // Abort at k=2, with start_i noise during the pass.
        rand_ops();
        run_pass(-1, 0, 1'b1, 1);
        rand_ops();
        run_pass(-1, 0, 1'b0, 0);

        // Reset while in DONE, then a full pass on the next cycle.
        rand_ops();
        run_pass(-1, 0, 1'b0, 2);
        rand_ops();
        run_pass(-1, 0, 1'b1, 0);

        for (int p = 0; p < 30; p++) begin
            rand_ops();
            run_pass(int'($urandom_range(0, N - 1)) - 1, int'($urandom_range(1, 4)),
                     1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
